// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for fifo_stream_reader and its 2-entry skid buffer.
package fifo_stream_reader_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_skid_buf_2.sv
// Two-entry in-order skid buffer: push at tail, pop from head, simultaneous push/pop keeps occupancy.
module fifo_skid_buf_2
  import fifo_stream_reader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic [P_DATA_WIDTH-1:0] i_data,
  input  logic                    i_pop,
  output skid_cnt_t               o_cnt,
  output logic [P_DATA_WIDTH-1:0] o_head
);

  logic [P_DATA_WIDTH-1:0] entry_0;
  logic [P_DATA_WIDTH-1:0] entry_1;
  skid_cnt_t               cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      entry_0 <= '0;
      entry_1 <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (cnt == 2'd0) entry_0 <= i_data;
          else             entry_1 <= i_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          entry_0 <= entry_1;
          cnt     <= cnt - 2'd1;
        end
        2'b11: begin
          // Head leaves; the arriving word lands behind whatever remains.
          if (cnt == 2'd1) begin
            entry_0 <= i_data;
          end else begin
            entry_0 <= entry_1;
            entry_1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cnt  = cnt;
  assign o_head = entry_0;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_pop && cnt == skid_cnt_t'(SKID_DEPTH)));

  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_pop && cnt == 2'd0));

  a_cnt_range: assert property (@(posedge i_clk) disable iff (i_rst)
    cnt <= skid_cnt_t'(SKID_DEPTH));

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-port to valid/ready stream adapter with burst o_last marking.
// Optional FIFO_STREAM_READER_BEAT_CNT_EN adds o_beat_total and o_burst_done.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 4,
  parameter int P_BURST_LEN  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output logic                    o_fifo_rd_en,
  input  logic [P_DATA_WIDTH-1:0] i_fifo_rdata,
  input  logic                    i_fifo_rempty,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic                    o_last
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  ,
  output logic [31:0]             o_beat_total,
  output logic                    o_burst_done
`endif
);

  localparam int BEAT_W = (clog2(P_BURST_LEN) < 1) ? 1 : clog2(P_BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(P_BURST_LEN - 1);

  skid_cnt_t         cnt;
  skid_cnt_t         occ_next;
  logic              pend;
  logic              pop;
  logic              rd_en;
  logic [BEAT_W-1:0] beat_cnt;

  assign pop     = o_valid && i_ready;
  assign o_valid = (cnt != 2'd0);
  assign o_last  = o_valid && (beat_cnt == LAST_BEAT);

  // Occupancy after this cycle's capture and pop; a new read may only be
  // issued if its word is guaranteed a free slot when it arrives.
  always_comb begin
    occ_next = cnt + skid_cnt_t'(pend) - skid_cnt_t'(pop);
    rd_en    = !i_rst && !i_fifo_rempty && (occ_next < skid_cnt_t'(SKID_DEPTH));
  end

  assign o_fifo_rd_en = rd_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pend <= 1'b0;
    else       pend <= rd_en;
  end

  fifo_skid_buf_2 #(
    .P_DATA_WIDTH (P_DATA_WIDTH)
  ) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (pend),
    .i_data (i_fifo_rdata),
    .i_pop  (pop),
    .o_cnt  (cnt),
    .o_head (o_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      if (o_last) beat_cnt <= '0;
      else        beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  logic [31:0] beat_total;
  logic        burst_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_total <= '0;
      burst_done <= 1'b0;
    end else begin
      if (pop) beat_total <= beat_total + 32'd1;
      burst_done <= pop && o_last;
    end
  end

  assign o_beat_total = beat_total;
  assign o_burst_done = burst_done;
`endif

  a_rd_only_when_nonempty: assert property (@(posedge i_clk) disable iff (i_rst)
    o_fifo_rd_en |-> !i_fifo_rempty);

  a_hold_while_stalled: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data)));

  a_in_flight_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    (cnt + skid_cnt_t'(pend)) <= skid_cnt_t'(SKID_DEPTH));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a one-cycle-latency FIFO read-port model.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic       rempty;
  logic       valid;
  logic       ready;
  logic       last;
  logic [3:0] rdata;
  logic [3:0] data;
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  logic [31:0] beat_total;
  logic        burst_done;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] fmem [0:255];
  int wp = 0;
  int rp = 0;
  int exp_beat = 0;

  always #5 clk = ~clk;

  assign rempty = (wp == rp);

  always @(posedge clk) begin
    if (rd_en) begin
      rdata <= fmem[rp[7:0]];
      rp    <= rp + 1;
    end
  end

  fifo_stream_reader #(
    .P_DATA_WIDTH (4),
    .P_BURST_LEN  (BURST)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_fifo_rd_en  (rd_en),
    .i_fifo_rdata  (rdata),
    .i_fifo_rempty (rempty),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_data        (data),
    .o_last        (last)
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
    ,
    .o_beat_total  (beat_total),
    .o_burst_done  (burst_done)
`endif
  );

  task automatic tick(input logic rdy);
    @(negedge clk);
    ready = rdy;
    #1;
  endtask

  task automatic push_word(input logic [3:0] w);
    fmem[wp[7:0]] = w;
    wp = wp + 1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    push_word(4'h7);
    #1;
    total++;
    if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en_nonempty: got %b want 0", rd_en); end
    wp = rp;
    #1;
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++;
    if (data !== 4'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data); end
    total++;
    if (last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", last); end
    @(negedge clk);
    rst = 1'b0;
    exp_beat = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1'b0);
      total++;
      if (rd_en !== 1'b0 || valid !== 1'b0) begin
        bad++; $display("FAIL idle_cycle%0d: rd_en=%b valid=%b want 0 0", c, rd_en, valid);
      end
    end
  endtask

  task automatic test_streaming();
    int t_rd, t_val, n;
    logic [3:0] exp_d;
    logic exp_l;
    t_rd = -1; t_val = -1; n = 0;
    tick(1'b1);
    for (int i = 1; i <= 8; i++) push_word(4'(i));
    #1;
    for (int c = 0; c < 40 && n < 8; c++) begin
      if (c > 0) tick(1'b1);
      if (t_rd < 0 && rd_en === 1'b1) t_rd = c;
      if (valid === 1'b1) begin
        if (t_val < 0) t_val = c;
        exp_d = 4'(n + 1);
        exp_l = (exp_beat == BURST - 1);
        total++;
        if (data !== exp_d || last !== exp_l || c != t_val + n) begin
          bad++; $display("FAIL stream_beat%0d: data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                          n, data, last, c, exp_d, exp_l, t_val + n);
        end
        exp_beat = (exp_beat == BURST - 1) ? 0 : exp_beat + 1;
        n++;
      end
    end
    total++;
    if (t_rd != 0 || t_val != 2) begin
      bad++; $display("FAIL stream_latency: rd_en@%0d valid@%0d want 0 and 2", t_rd, t_val);
    end
    total++;
    if (n != 8) begin bad++; $display("FAIL stream_count: got %0d beats want 8", n); end
  endtask

  task automatic test_backpressure();
    int n, rp0;
    logic pv, pr;
    logic [3:0] pd, exp_d;
    logic exp_l;
    n = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    rp0 = rp;
    tick(1'b1);
    for (int i = 1; i <= 8; i++) push_word(4'(i));
    #1;
    for (int c = 0; c < 80 && n < 8; c++) begin
      if (c > 0) tick((c % 3) == 0);
      total++;
      if ((rp - rp0) - n > 2) begin
        bad++; $display("FAIL bp_outstanding_cyc%0d: got %0d want <=2", c, (rp - rp0) - n);
      end
      if (pv && !pr) begin
        total++;
        if (valid !== 1'b1 || data !== pd) begin
          bad++; $display("FAIL bp_hold_cyc%0d: valid=%b data=%h want 1 %h", c, valid, data, pd);
        end
      end
      if (valid === 1'b1 && ready === 1'b1) begin
        exp_d = 4'(n + 1);
        exp_l = (exp_beat == BURST - 1);
        total++;
        if (data !== exp_d || last !== exp_l) begin
          bad++; $display("FAIL bp_beat%0d: data=%h last=%b want %h %b", n, data, last, exp_d, exp_l);
        end
        exp_beat = (exp_beat == BURST - 1) ? 0 : exp_beat + 1;
        n++;
      end
      pv = valid; pr = ready; pd = data;
    end
    total++;
    if (n != 8) begin bad++; $display("FAIL bp_count: got %0d beats want 8", n); end
  endtask

  task automatic test_underflow();
    int n, gap;
    logic [3:0] exp_d;
    logic exp_l;
    n = 0; gap = 0;
    tick(1'b1);
    push_word(4'h1);
    push_word(4'h2);
    #1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (c > 0) tick(1'b1);
      if (c == 5) begin
        push_word(4'h3);
        push_word(4'h4);
        #1;
      end
      if (valid === 1'b1) begin
        exp_d = 4'(n + 1);
        exp_l = (exp_beat == BURST - 1);
        total++;
        if (data !== exp_d || last !== exp_l) begin
          bad++; $display("FAIL uf_beat%0d: data=%h last=%b want %h %b", n, data, last, exp_d, exp_l);
        end
        exp_beat = (exp_beat == BURST - 1) ? 0 : exp_beat + 1;
        n++;
      end else if (n == 2) begin
        gap++;
      end
    end
    total++;
    if (gap == 0) begin bad++; $display("FAIL uf_gap: got %0d idle cycles want >0", gap); end
    total++;
    if (n != 4) begin bad++; $display("FAIL uf_count: got %0d beats want 4", n); end
  endtask

  task automatic test_async_reset();
    int n;
    logic [3:0] exp_d;
    logic exp_l;
    n = 0;
    tick(1'b1);
    for (int i = 1; i <= 5; i++) push_word(4'(i));
    #1;
    for (int c = 0; c < 20 && n < 1; c++) begin
      if (c > 0) tick(1'b1);
      if (valid === 1'b1) n++;
    end
    repeat (5) tick(1'b0);
    total++;
    if (valid !== 1'b1 || data !== 4'h2) begin
      bad++; $display("FAIL ar_prefill: valid=%b data=%h want 1 2", valid, data);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (valid !== 1'b0 || rd_en !== 1'b0 || last !== 1'b0) begin
      bad++; $display("FAIL ar_immediate: valid=%b rd_en=%b last=%b want 0 0 0", valid, rd_en, last);
    end
    wp = rp;
    exp_beat = 0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    tick(1'b1);
    for (int i = 0; i < 4; i++) push_word(4'(10 + i));
    #1;
    for (int c = 0; c < 30 && n < 4; c++) begin
      if (c > 0) tick(1'b1);
      if (valid === 1'b1) begin
        exp_d = 4'(10 + n);
        exp_l = (n == 3);
        total++;
        if (data !== exp_d || last !== exp_l) begin
          bad++; $display("FAIL ar_beat%0d: data=%h last=%b want %h %b", n, data, last, exp_d, exp_l);
        end
        n++;
      end
    end
    exp_beat = 0;
    total++;
    if (n != 4) begin bad++; $display("FAIL ar_count: got %0d beats want 4", n); end
  endtask

`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  task automatic test_beat_total();
    int n, pulses;
    logic prev_last_hs;
    n = 0; pulses = 0; prev_last_hs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wp = rp;
    @(negedge clk);
    rst = 1'b0;
    exp_beat = 0;
    #1;
    total++;
    if (beat_total !== 32'd0) begin bad++; $display("FAIL mc_total_reset: got %0d want 0", beat_total); end
    tick(1'b1);
    for (int i = 1; i <= 8; i++) push_word(4'(i));
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick(1'b1);
      total++;
      if (burst_done !== prev_last_hs) begin
        bad++; $display("FAIL mc_burst_done_cyc%0d: got %b want %b", c, burst_done, prev_last_hs);
      end
      if (burst_done === 1'b1) pulses++;
      prev_last_hs = valid && ready && last;
      if (valid === 1'b1) n++;
    end
    total++;
    if (beat_total !== 32'd8) begin bad++; $display("FAIL mc_total: got %0d want 8", beat_total); end
    total++;
    if (pulses != 2) begin bad++; $display("FAIL mc_pulses: got %0d want 2", pulses); end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_underflow();
    test_async_reset();
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
    test_beat_total();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 ns");
    $fatal(1);
  end

endmodule
